// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control unit: state enum, mux-select
// codes, ALU control codes and Funct[4:1] opcode constants.
// MAIN_FSM_ILLEGAL_TRAP_EN adds the TRAP state to the enum.
package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
    ,TRAP    = 4'd10
`endif
  } state_t;

  // ALUSrcB select
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // ResultSrc select
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // ALUControl
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  // Funct[4:1] data-processing opcodes
  localparam logic [3:0] FN_AND = 4'b0000;
  localparam logic [3:0] FN_SUB = 4'b0010;
  localparam logic [3:0] FN_ADD = 4'b0100;
  localparam logic [3:0] FN_CMP = 4'b1010;
  localparam logic [3:0] FN_ORR = 4'b1100;

endpackage

// File: rtl/alu_field_dec.sv
// Combinational ALU-field decoder: maps Funct to ALUControl, the NZ/CV
// flag-write requests and the compare (no-write) indication.
module alu_field_dec
  import ctrl_pkg::*;
(
  input  logic       alu_op,
  input  logic [5:0] funct,
  output logic [1:0] alu_control,
  output logic [1:0] flag_w,
  output logic       no_write
);

  // Decode Funct[4:1] only in execute states; otherwise everything is idle.
  always_comb begin
    alu_control = ALU_ADD;
    flag_w      = 2'b00;
    no_write    = 1'b0;
    if (alu_op) begin
      unique case (funct[4:1])
        FN_ADD:  alu_control = ALU_ADD;
        FN_SUB:  alu_control = ALU_SUB;
        FN_AND:  alu_control = ALU_AND;
        FN_ORR:  alu_control = ALU_ORR;
        FN_CMP: begin
          alu_control = ALU_SUB;
          no_write    = 1'b1;
        end
        default: alu_control = ALU_ADD;
      endcase
      // C/V only mean something for arithmetic results.
      flag_w[1] = funct[0];
      flag_w[0] = funct[0] & ((alu_control == ALU_ADD) | (alu_control == ALU_SUB));
    end
  end

endmodule

// File: rtl/main_control_fsm.sv
// Multicycle ARM-subset main control FSM (Moore) with ALU-field decode.
// Optional MAIN_FSM_ILLEGAL_TRAP_EN: Op=11 traps into a sticky TRAP state
// that raises Illegal until reset; without it Op=11 returns to FETCH.
module main_control_fsm
  import ctrl_pkg::*;
#(
  parameter logic [3:0] RD_PC = 4'hF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUControl,
  output logic [1:0] FlagW,
  output logic       NoWrite,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       PCS,
  output logic       Illegal
);

  state_t state_q, state_d;
  state_t eff_state;
  logic   alu_op;
  logic   branch;

  // While reset is held the outputs decode as FETCH so selects are stable.
  assign eff_state = reset ? FETCH : state_q;

  alu_field_dec u_alu_dec (
    .alu_op      (alu_op),
    .funct       (Funct),
    .alu_control (ALUControl),
    .flag_w      (FlagW),
    .no_write    (NoWrite)
  );

  // State register with synchronous reset to FETCH.
  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // Next-state logic; instruction fields are consulted only in decision states.
  always_comb begin
    state_d = FETCH;
    unique case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        unique case (Op)
          2'b00:   state_d = Funct[5] ? EXECI : EXECR;
          2'b01:   state_d = MEMADR;
          2'b10:   state_d = BRANCH;
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
          default: state_d = TRAP;
`else
          default: state_d = FETCH;
`endif
        endcase
      end
      MEMADR:       state_d = Funct[0] ? MEMREAD : MEMWRITE;
      MEMREAD:      state_d = MEMWB;
      EXECR, EXECI: state_d = NoWrite ? FETCH : ALUWB;
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
      TRAP:         state_d = TRAP;
`endif
      default:      state_d = FETCH;
    endcase
  end

  // Moore output decode from the (reset-qualified) registered state.
  always_comb begin
    IRWrite   = 1'b0;
    NextPC    = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = SRCB_REG;
    ResultSrc = RES_ALUOUT;
    RegW      = 1'b0;
    MemW      = 1'b0;
    alu_op    = 1'b0;
    branch    = 1'b0;
    Illegal   = 1'b0;
    unique case (eff_state)
      FETCH: begin
        IRWrite   = ~reset;
        NextPC    = ~reset;
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
      end
      MEMADR:   ALUSrcB = SRCB_IMM;
      MEMREAD:  AdrSrc  = 1'b1;
      MEMWB: begin
        ResultSrc = RES_DATA;
        RegW      = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc = 1'b1;
        MemW   = 1'b1;
      end
      EXECR:    alu_op = 1'b1;
      EXECI: begin
        ALUSrcB = SRCB_IMM;
        alu_op  = 1'b1;
      end
      ALUWB:    RegW = 1'b1;
      BRANCH: begin
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALU;
        branch    = 1'b1;
      end
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
      TRAP:     Illegal = 1'b1;
`endif
      default: ;
    endcase
  end

  // A write to the PC register or a branch redirects the PC.
  assign PCS = (RegW & (Rd == RD_PC)) | branch;

endmodule

// File: tb/tb_main_control_fsm.sv
// Randomized self-checking bench for main_control_fsm: an instruction-level
// model expands each instruction into its expected per-cycle output vector.
module tb_main_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic       IRWrite, AdrSrc, ALUSrcA, NoWrite, NextPC, RegW, MemW, PCS, Illegal;
  logic [1:0] ALUSrcB, ResultSrc, ALUControl, FlagW;

  main_control_fsm dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd),
    .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ALUControl(ALUControl), .FlagW(FlagW),
    .NoWrite(NoWrite), .NextPC(NextPC), .RegW(RegW), .MemW(MemW),
    .PCS(PCS), .Illegal(Illegal)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // {IRWrite,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,ALUControl,FlagW,NoWrite,NextPC,RegW,MemW,PCS,Illegal}
  logic [16:0] obs;
  assign obs = {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl, FlagW,
                NoWrite, NextPC, RegW, MemW, PCS, Illegal};

  task automatic chk(input string tag, input logic [16:0] got, input logic [16:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%05h exp=%05h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [16:0] pk(input bit irw, input bit adr, input bit sa,
      input logic [1:0] sb, input logic [1:0] rs, input logic [1:0] ac,
      input logic [1:0] fw, input bit nw, input bit np, input bit rw,
      input bit mw, input bit pcs, input bit ill);
    return {irw, adr, sa, sb, rs, ac, fw, nw, np, rw, mw, pcs, ill};
  endfunction

  typedef struct {
    string       tag;
    logic [16:0] v;
    bit          free;  // instruction fields are don't-care in this cycle
  } cyc_t;

  cyc_t q[$];

  // Data-processing behaviour by Funct[4:1]
  function automatic void alu_ref(input logic [3:0] c, output logic [1:0] ac, output bit nw);
    nw = 1'b0;
    case (c)
      4'b0100: ac = 2'd0;
      4'b0010: ac = 2'd1;
      4'b0000: ac = 2'd2;
      4'b1100: ac = 2'd3;
      4'b1010: begin ac = 2'd1; nw = 1'b1; end
      default: ac = 2'd0;
    endcase
  endfunction

  // Expand one instruction into its expected cycle-by-cycle outputs.
  function automatic void build(input logic [1:0] op, input logic [5:0] f, input logic [3:0] rd);
    bit          pc = (rd == 4'hF);
    logic [1:0]  ac;
    logic [1:0]  fw;
    bit          nw;
    q.delete();
    q.push_back('{"fetch",  pk(1,0,1,2'd2,2'd2,2'd0,2'd0,0,1,0,0,0,0), 1'b1});
    q.push_back('{"decode", pk(0,0,1,2'd2,2'd2,2'd0,2'd0,0,0,0,0,0,0), 1'b0});
    case (op)
      2'b01: begin
        q.push_back('{"memadr", pk(0,0,0,2'd1,2'd0,2'd0,2'd0,0,0,0,0,0,0), 1'b0});
        if (f[0]) begin
          q.push_back('{"memread", pk(0,1,0,2'd0,2'd0,2'd0,2'd0,0,0,0,0,0,0), 1'b1});
          q.push_back('{"memwb",   pk(0,0,0,2'd0,2'd1,2'd0,2'd0,0,0,1,0,pc,0), 1'b1});
        end else begin
          q.push_back('{"memwrite", pk(0,1,0,2'd0,2'd0,2'd0,2'd0,0,0,0,1,0,0), 1'b1});
        end
      end
      2'b00: begin
        alu_ref(f[4:1], ac, nw);
        fw = {f[0], f[0] & (ac == 2'd0 || ac == 2'd1)};
        q.push_back('{"exec", pk(0,0,0,{1'b0,f[5]},2'd0,ac,fw,nw,0,0,0,0,0), 1'b0});
        if (!nw)
          q.push_back('{"aluwb", pk(0,0,0,2'd0,2'd0,2'd0,2'd0,0,0,1,0,pc,0), 1'b1});
      end
      2'b10:
        q.push_back('{"branch", pk(0,0,0,2'd1,2'd2,2'd0,2'd0,0,0,0,0,1,0), 1'b1});
      default: begin
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
        for (int k = 0; k < 4; k++)
          q.push_back('{"trap", pk(0,0,0,2'd0,2'd0,2'd0,2'd0,0,0,0,0,0,1), 1'b1});
`endif
      end
    endcase
  endfunction

  // Entry/exit point: #1 after a rising edge.
  task automatic do_reset(input int n);
    logic [31:0] r;
    reset = 1'b1;
    for (int k = 0; k < n; k++) begin
      r = $urandom;
      Op = r[1:0]; Funct = r[7:2]; Rd = r[11:8];
      @(negedge clk);
      chk("reset", obs, pk(0,0,1,2'd2,2'd2,2'd0,2'd0,0,0,0,0,0,0));
      @(posedge clk); #1;
    end
    reset = 1'b0;
  endtask

  // Run one instruction; stop >= 0 aborts at that cycle with a reset.
  task automatic run_instr(input logic [1:0] op, input logic [5:0] f,
                           input logic [3:0] rd, input int stop);
    logic [31:0] r;
    build(op, f, rd);
    for (int i = 0; i < q.size(); i++) begin
      if (i == stop) break;
      Rd = rd;
      if (q[i].free) begin
        r = $urandom;
        Op = r[1:0]; Funct = r[7:2];
      end else begin
        Op = op; Funct = f;
      end
      @(negedge clk);
      chk(q[i].tag, obs, q[i].v);
      @(posedge clk); #1;
    end
    if (stop >= 0) do_reset(1);
`ifdef MAIN_FSM_ILLEGAL_TRAP_EN
    else if (op == 2'b11) do_reset(1);
`endif
  endtask

  logic [3:0] codes [5];

  initial begin
    logic [31:0] r;
    logic [5:0]  f;
    int          stop;
    codes[0] = 4'b0100; codes[1] = 4'b0010; codes[2] = 4'b0000;
    codes[3] = 4'b1100; codes[4] = 4'b1010;
    reset = 1'b1; Op = 2'b00; Funct = 6'd0; Rd = 4'd0;
    @(posedge clk); #1;
    do_reset(2);

    // Directed instructions
    run_instr(2'b01, 6'b011001, 4'hF, -1);  // LDR to PC
    run_instr(2'b01, 6'b011001, 4'h3, -1);  // LDR
    run_instr(2'b01, 6'b011000, 4'h2, -1);  // STR
    run_instr(2'b00, 6'b001001, 4'h1, -1);  // ADDS reg
    run_instr(2'b00, 6'b000001, 4'hF, -1);  // ANDS reg to PC
    run_instr(2'b00, 6'b110101, 4'h4, -1);  // CMP imm
    run_instr(2'b10, 6'b100000, 4'h0, -1);  // B
    run_instr(2'b11, 6'b000000, 4'h0, -1);  // undefined op
    run_instr(2'b01, 6'b011001, 4'h5, 3);   // reset mid-load
    run_instr(2'b00, 6'b001000, 4'h5, -1);

    // Random instructions, occasionally interrupted by reset
    for (int n = 0; n < 300; n++) begin
      r = $urandom;
      f = r[7:2];
      if (r[12]) f[4:1] = codes[r[15:13] % 5];
      build(r[1:0], f, r[11:8]);
      stop = (r[19:16] == 4'd0) ? int'($urandom_range(0, q.size() - 1)) : -1;
      run_instr(r[1:0], f, r[11:8], stop);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
